// File: rtl/vga_upd_arb_pkg.sv
// rtl/vga_upd_arb_pkg.sv - shared vga board constants, arbiter state encoding and address helper
package vga_upd_arb_pkg;

    localparam int VGA_CELLS_X = 60;
    localparam int VGA_CELLS_Y = 44;
    localparam int VGA_ADDR_W  = 12;
    localparam int VGA_COORD_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_SPENT  = 2'd2
    } vga_arb_state_t;

    // y*cells_x + x as (y << ceil(log2 cells_x)) minus shifted copies of y for each set bit
    // of the gap to the next power of two; for 60 this is (y<<6) - (y<<2) + x.
    function automatic logic [VGA_ADDR_W-1:0] vga_lin_addr(
        input logic [VGA_COORD_W-1:0] x,
        input logic [VGA_COORD_W-1:0] y,
        input int                     cells_x
    );
        logic [VGA_ADDR_W-1:0] acc;
        logic [VGA_ADDR_W-1:0] yw;
        int                    sh;
        int                    gap;
        sh  = $clog2(cells_x);
        gap = (1 << sh) - cells_x;
        yw  = {{(VGA_ADDR_W-VGA_COORD_W){1'b0}}, y};
        acc = yw << sh;
        for (int i = 0; i < VGA_ADDR_W; i++) begin
            if (gap[i]) acc = acc - (yw << i);
        end
        return acc + {{(VGA_ADDR_W-VGA_COORD_W){1'b0}}, x};
    endfunction

endpackage

// File: rtl/vga_upd_arb_rr_pick.sv
// rtl/vga_upd_arb_rr_pick.sv - round-robin pick of one request, searching upward from ptr
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_upd_arb.sv
// rtl/vga_upd_arb.sv - vblank-windowed, budgeted round-robin arbiter for board-cell writes
module vga_upd_arb
    import vga_upd_arb_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int CELLS_X = VGA_CELLS_X,
    parameter int CELLS_Y = VGA_CELLS_Y,
    parameter int MAX_WR  = 64
) (
    input  logic                              I_clk,
    input  logic                              I_rst,
    input  logic                              I_vblank,
    input  logic [N_REQ-1:0]                  I_req,
    input  logic [VGA_COORD_W*N_REQ-1:0]      I_x,
    input  logic [VGA_COORD_W*N_REQ-1:0]      I_y,
    input  logic [N_REQ-1:0]                  I_val,
    output logic [N_REQ-1:0]                  O_gnt,
    output logic                              O_we,
    output logic [VGA_ADDR_W-1:0]             O_waddr,
    output logic                              O_wdata,
    output logic                              O_err,
    output logic                              O_busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_WR + 1);
    localparam logic [VGA_COORD_W:0] CX = (VGA_COORD_W+1)'(CELLS_X);
    localparam logic [VGA_COORD_W:0] CY = (VGA_COORD_W+1)'(CELLS_Y);

    vga_arb_state_t           state;
    vga_arb_state_t           nstate;
    logic                     vblank_q;
    logic                     vblank_rise;
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            ptr;
    logic [N_REQ-1:0]         mask;
    logic [N_REQ-1:0]         pick_oh;
    logic [IW-1:0]            pick_idx;
    logic                     pick_any;
    logic                     sel;
    logic                     busy_nxt;
    logic                     enter_win;
    logic [VGA_COORD_W-1:0]   cur_x;
    logic [VGA_COORD_W-1:0]   cur_y;
    logic                     cur_val;
    logic                     in_range;
    logic [VGA_ADDR_W-1:0]    addr;

    assign vblank_rise = I_vblank & ~vblank_q;

    // A requester whose grant is on the output this cycle is already served.
    assign mask = I_req & ~O_gnt;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req    (mask),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel      = (state == ST_WINDOW) && pick_any;
    assign cur_x    = I_x[int'(pick_idx)*VGA_COORD_W +: VGA_COORD_W];
    assign cur_y    = I_y[int'(pick_idx)*VGA_COORD_W +: VGA_COORD_W];
    assign cur_val  = I_val[pick_idx];
    assign in_range = ({1'b0, cur_x} < CX) && ({1'b0, cur_y} < CY);
    assign addr     = vga_lin_addr(cur_x, cur_y, CELLS_X);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: begin
                if (vblank_rise) nstate = ST_WINDOW;
            end
            ST_WINDOW: begin
                if (!I_vblank) nstate = ST_IDLE;
                else if (sel && (cnt == CW'(MAX_WR - 1))) nstate = ST_SPENT;
            end
            ST_SPENT: begin
                if (!I_vblank) nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt  = (nstate == ST_WINDOW);
        enter_win = (state != ST_WINDOW) && (nstate == ST_WINDOW);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            vblank_q <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
        end else begin
            vblank_q <= I_vblank;
            if (enter_win) cnt <= '0;
            else if (sel)  cnt <= cnt + CW'(1);
            if (sel) ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    // Out-of-range grants still pulse O_gnt and consume budget, but never write.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_gnt   <= '0;
            O_we    <= 1'b0;
            O_waddr <= '0;
            O_wdata <= 1'b0;
            O_err   <= 1'b0;
            O_busy  <= 1'b0;
        end else begin
            O_gnt   <= sel ? pick_oh : '0;
            O_we    <= sel & in_range;
            O_waddr <= (sel && in_range) ? addr : '0;
            O_wdata <= sel & in_range & cur_val;
            O_err   <= sel & ~in_range;
            O_busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vga_upd_arb.sv
// tb/tb_vga_upd_arb.sv - directed vector bench for vga_upd_arb
module tb_vga_upd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic [2:0]  req;
    logic [17:0] xs;
    logic [17:0] ys;
    logic [2:0]  vals;

    logic [2:0]  a_gnt, b_gnt;
    logic        a_we, b_we;
    logic [11:0] a_waddr, b_waddr;
    logic        a_wdata, b_wdata;
    logic        a_err, b_err;
    logic        a_busy, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_upd_arb dut_a (
        .I_clk(clk), .I_rst(rst), .I_vblank(vblank), .I_req(req),
        .I_x(xs), .I_y(ys), .I_val(vals),
        .O_gnt(a_gnt), .O_we(a_we), .O_waddr(a_waddr), .O_wdata(a_wdata),
        .O_err(a_err), .O_busy(a_busy)
    );

    vga_upd_arb #(.MAX_WR(4)) dut_b (
        .I_clk(clk), .I_rst(rst), .I_vblank(vblank), .I_req(req),
        .I_x(xs), .I_y(ys), .I_val(vals),
        .O_gnt(b_gnt), .O_we(b_we), .O_waddr(b_waddr), .O_wdata(b_wdata),
        .O_err(b_err), .O_busy(b_busy)
    );

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  x;
        logic [5:0]  y;
        logic        val;
        logic [2:0]  gnt;
        logic        we;
        logic [11:0] addr;
        logic        wdata;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        int nwe;
        int late;
        logic [2:0] fair_exp[6];

        vecs[0] = '{3'b001,  6'd5,  6'd2, 1'b1, 3'b001, 1'b1, 12'd125,  1'b1, 1'b0};
        vecs[1] = '{3'b010, 6'd60,  6'd0, 1'b1, 3'b010, 1'b0, 12'd0,    1'b0, 1'b1};
        vecs[2] = '{3'b010, 6'd59, 6'd44, 1'b1, 3'b010, 1'b0, 12'd0,    1'b0, 1'b1};
        vecs[3] = '{3'b010, 6'd59, 6'd43, 1'b1, 3'b010, 1'b1, 12'd2639, 1'b1, 1'b0};
        vecs[4] = '{3'b100,  6'd0,  6'd0, 1'b0, 3'b100, 1'b1, 12'd0,    1'b0, 1'b0};
        vecs[5] = '{3'b100, 6'd63, 6'd63, 1'b1, 3'b100, 1'b0, 12'd0,    1'b0, 1'b1};
        vecs[6] = '{3'b001,  6'd0, 6'd43, 1'b1, 3'b001, 1'b1, 12'd2580, 1'b1, 1'b0};
        vecs[7] = '{3'b010, 6'd59,  6'd0, 1'b0, 3'b010, 1'b1, 12'd59,   1'b0, 1'b0};
        vecs[8] = '{3'b100, 6'd10, 6'd10, 1'b1, 3'b100, 1'b1, 12'd610,  1'b1, 1'b0};
        fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        rst = 1'b1; vblank = 1'b0; req = '0; xs = '0; ys = '0; vals = '0;
        step(); step();
        chk("rst_gnt", a_gnt, 0);
        chk("rst_we", a_we, 0);
        chk("rst_waddr", a_waddr, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_err", a_err, 0);
        chk("rst_busy", a_busy, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", a_busy, 0);

        vblank = 1'b1;
        step();
        chk("rise_busy", a_busy, 1);

        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req; xs = {3{vecs[i].x}}; ys = {3{vecs[i].y}}; vals = {3{vecs[i].val}};
            step();
            chk($sformatf("v%0d_gnt", i), a_gnt, vecs[i].gnt);
            chk($sformatf("v%0d_we", i), a_we, vecs[i].we);
            chk($sformatf("v%0d_waddr", i), a_waddr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), a_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_err", i), a_err, vecs[i].err);
            req = '0;
            step();
            chk($sformatf("v%0d_gnt_off", i), a_gnt, 0);
            chk($sformatf("v%0d_we_off", i), a_we, 0);
        end

        xs = {6'd3, 6'd2, 6'd1}; ys = {3{6'd1}}; vals = 3'b111; req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("fair%0d_gnt", k), a_gnt, fair_exp[k]);
        end
        req = '0;
        step();
        chk("fair_end_gnt", a_gnt, 0);

        vblank = 1'b0;
        step(); step();
        chk("budget_pre_busy", b_busy, 0);
        vblank = 1'b1; req = 3'b111;
        nwe = 0; late = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 4) chk("budget_busy_k4", b_busy, 1);
            if (k == 5) begin
                chk("budget_busy_k5", b_busy, 0);
                chk("budget_a_busy_k5", a_busy, 1);
            end
            nwe += int'(b_we);
            if (k > 5) late += int'(b_we);
        end
        chk("budget_writes", nwe, 4);
        chk("spent_writes", late, 0);

        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        chk("refresh_busy", b_busy, 1);
        nwe = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            nwe += int'(b_we);
        end
        chk("refresh_writes", nwe, 4);

        req = '0; vblank = 1'b0;
        step(); step();
        vblank = 1'b1;
        step();
        chk("edge_busy", a_busy, 1);
        req = 3'b001; xs = {3{6'd1}}; ys = {3{6'd1}}; vals = 3'b111; vblank = 1'b0;
        step();
        chk("edge_gnt", a_gnt, 3'b001);
        chk("edge_we", a_we, 1);
        chk("edge_waddr", a_waddr, 61);
        chk("edge_busy_low", a_busy, 0);
        step();
        chk("edge_after_we", a_we, 0);
        chk("edge_after_gnt", a_gnt, 0);
        step();
        chk("edge_after2_we", a_we, 0);
        req = '0;

        vblank = 1'b1;
        step();
        req = 3'b111;
        step();
        chk("pre_rst_gnt", a_gnt, 3'b010);
        chk("pre_rst_waddr", a_waddr, 61);
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", a_gnt, 0);
        chk("async_rst_we", a_we, 0);
        chk("async_rst_waddr", a_waddr, 0);
        chk("async_rst_busy", a_busy, 0);
        step();
        rst = 1'b0; req = '0;
        late = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            late += int'(a_we) + int'(a_gnt != 3'b000);
        end
        chk("post_rst_no_write", late, 0);
        chk("post_rst_busy", a_busy, 1);
        req = 3'b111;
        step();
        chk("post_rst_ptr_gnt", a_gnt, 3'b001);
        req = '0; vblank = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
